// File: rtl/alu_seq_unit.sv
// Registered ALU with operand/result handshakes, serial variable shifts and status flags.
// Uses the MIPS funct opcodes of the earlier combinational 8-bit ALU, now with a parametrised width.
module alu_seq_unit #(
    parameter  int NB_DATA  = 8,
    parameter  int NB_OP    = 6,
    localparam int NB_SHAMT = $clog2(NB_DATA)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NB_DATA-1:0] dato_a,
    input  logic [NB_DATA-1:0] dato_b,
    input  logic [NB_OP-1:0]   opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NB_DATA-1:0] out,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_ovf,
    output logic               flag_err
);
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SLL = NB_OP'(6'b000000);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    typedef struct packed {
        logic [NB_DATA-1:0] a;
        logic [NB_DATA-1:0] b;
        logic [NB_OP-1:0]   op;
    } req_t;

    state_t              state, state_nxt;
    req_t                req;
    logic                rdy_en;
    logic                accept;
    logic                in_is_shift;
    logic [NB_SHAMT-1:0] cnt;
    logic [NB_DATA-1:0]  shreg, sh_step, sh_res;
    logic [NB_DATA-1:0]  alu_res;
    logic                alu_c, alu_v, alu_e;
    logic [NB_DATA:0]    sum, diff;

    assign in_is_shift = (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA);
    assign accept      = in_ready && in_valid;

    // in_ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && rdy_en) state_nxt = in_is_shift ? SHIFT : EXEC;
            EXEC:    state_nxt = DONE;
            SHIFT:   if (cnt <= NB_SHAMT'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rdy_en && (state == IDLE);
        out_valid = (state == DONE);
    end

    // one-bit step of the serial shifter; shamt 0 passes the operand through
    always_comb begin
        sh_step = shreg;
        case (req.op)
            OP_SLL:  sh_step = {shreg[NB_DATA-2:0], 1'b0};
            OP_SRL:  sh_step = {1'b0, shreg[NB_DATA-1:1]};
            OP_SRA:  sh_step = {shreg[NB_DATA-1], shreg[NB_DATA-1:1]};
            default: sh_step = shreg;
        endcase
        sh_res = (cnt == '0) ? shreg : sh_step;
    end

    assign sum  = {1'b0, req.a} + {1'b0, req.b};
    assign diff = {1'b0, req.a} - {1'b0, req.b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (req.op)
            OP_ADD: begin
                alu_res = sum[NB_DATA-1:0];
                alu_c   = sum[NB_DATA];
                alu_v   = (req.a[NB_DATA-1] == req.b[NB_DATA-1]) &&
                          (sum[NB_DATA-1] != req.a[NB_DATA-1]);
            end
            OP_SUB: begin
                alu_res = diff[NB_DATA-1:0];
                alu_c   = diff[NB_DATA];
                alu_v   = (req.a[NB_DATA-1] != req.b[NB_DATA-1]) &&
                          (diff[NB_DATA-1] != req.a[NB_DATA-1]);
            end
            OP_AND:  alu_res = req.a & req.b;
            OP_OR:   alu_res = req.a | req.b;
            OP_XOR:  alu_res = req.a ^ req.b;
            OP_NOR:  alu_res = ~(req.a | req.b);
            default: alu_e   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req        <= '0;
            cnt        <= '0;
            shreg      <= '0;
            out        <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            if (accept) begin
                req   <= '{a: dato_a, b: dato_b, op: opcode};
                cnt   <= dato_b[NB_SHAMT-1:0];
                shreg <= dato_a;
            end
            if (state == EXEC) begin
                out        <= alu_res;
                flag_zero  <= (alu_res == '0);
                flag_carry <= alu_c;
                flag_ovf   <= alu_v;
                flag_err   <= alu_e;
            end
            if (state == SHIFT) begin
                if (cnt <= NB_SHAMT'(1)) begin
                    out        <= sh_res;
                    flag_zero  <= (sh_res == '0);
                    flag_carry <= 1'b0;
                    flag_ovf   <= 1'b0;
                    flag_err   <= 1'b0;
                end else begin
                    shreg <= sh_step;
                    cnt   <= cnt - NB_SHAMT'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed vectors push expectations, a negedge monitor checks results.
module tb_alu_seq_unit;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                           OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                           SLL = 6'b000000, SRL = 6'b000010, SRA = 6'b000011, BAD = 6'b111111;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [7:0] dato_a = '0, dato_b = '0, out;
    logic [5:0] opcode = '0;
    logic       flag_zero, flag_carry, flag_ovf, flag_err;

    alu_seq_unit #(.NB_DATA(8), .NB_OP(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dato_a(dato_a), .dato_b(dato_b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic [3:0] f;   // {zero, carry, ovf, err}
        int         c;   // cycle count at which the result must first appear
    } exp_t;

    exp_t q[$];
    int   cyc = 0, nvec = 0, nerr = 0;
    logic seen = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else if (out_valid && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("out", out, e.o);
                chk("flags", {flag_zero, flag_carry, flag_ovf, flag_err}, e.f);
                chk("latency", cyc, e.c);
            end
        end else if (!out_valid) seen = 1'b0;
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] eo, input logic [3:0] ef, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        dato_a = a; dato_b = b; opcode = op; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{eo, ef, cyc + 1 + lat});
        @(posedge clk);
        #1 in_valid = 1'b0;
        dato_a = ~a; dato_b = ~b; opcode = ADD;   // must not disturb the captured operation
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_flags", {flag_zero, flag_carry, flag_ovf, flag_err}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1 chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk); #1 chk("in_ready_after_edge", in_ready, 1);

        issue(8,   2,   ADD,  10,  4'b0000, 1, 1);
        issue(8,   2,   SUB,  6,   4'b0000, 1, 1);
        issue(2,   8,   SUB,  250, 4'b0100, 1, 1);
        issue(127, 1,   ADD,  128, 4'b0010, 1, 1);
        issue(255, 1,   ADD,  0,   4'b1100, 1, 1);
        issue(3,   1,   OR_,  3,   4'b0000, 1, 1);
        issue(3,   1,   XOR_, 2,   4'b0000, 1, 1);
        issue(3,   1,   NOR_, 252, 4'b0000, 1, 1);
        issue(3,   1,   AND_, 1,   4'b0000, 1, 1);
        issue(3,   1,   BAD,  0,   4'b1001, 1, 1);
        issue(131, 1,   SRA,  193, 4'b0000, 1, 1);
        issue(131, 3,   SRL,  16,  4'b0000, 3, 1);
        issue(3,   0,   SLL,  3,   4'b0000, 1, 1);
        issue(131, 8'h0B, SRL, 16, 4'b0000, 3, 1);
        issue(1,   3,   SLL,  8,   4'b0000, 3, 1);
        issue(128, 1,   SLL,  0,   4'b1000, 1, 1);
        drain();

        // backpressure: result held, new requests ignored
        out_ready = 1'b0;
        issue(8, 2, SUB, 6, 4'b0000, 1, 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; dato_a = 8'd99; dato_b = 8'd1; opcode = ADD;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out", out, 6);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_out_retained", out, 6);

        // reset during a serial shift aborts it and clears outputs at once
        issue(2, 8, SUB, 250, 4'b0100, 1, 1);
        drain();
        issue(131, 7, SRL, 0, 4'b0000, 7, 0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out", out, 0);
        chk("abort_flags", {flag_zero, flag_carry, flag_ovf, flag_err}, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 chk("post_rst_in_ready", in_ready, 1);
        issue(1, 1, ADD, 2, 4'b0000, 1, 1);
        drain();
        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Registered, parametrised-width successor of the 8-bit combinational ALU; same 6-bit MIPS-style funct opcodes.
- Adds a valid/ready operand handshake, multi-cycle serial shifts with a variable amount, a held result with backpressure, status flags, and an invalid-opcode error.
- Sits between the operand-loading front end (switch/button capture) and the result display/consumer.

Parameters:
- NB_DATA, 8: operand/result width; must be >= 4 and a power of 2.
- NB_OP, 6: opcode width.
- NB_SHAMT, $clog2(NB_DATA): shift-amount width, derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- dato_a  in  NB_DATA  operand A.
- dato_b  in  NB_DATA  operand B; bits [NB_SHAMT-1:0] are the shift amount for shifts.
- opcode  in  NB_OP  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- out  out  NB_DATA  result.
- flag_zero  out  1  out == 0.
- flag_carry  out  1  ADD carry-out / SUB borrow.
- flag_ovf  out  1  signed overflow (ADD/SUB).
- flag_err  out  1  unsupported opcode.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out, all flags, out_valid = 0; in_ready = 0 while rst_n=0 and 1 from the first edge after release. Reset mid-operation aborts it and drops the result.
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid at an edge, capture dato_a, dato_b, opcode into internal registers. Go to SHIFT for shift opcodes, otherwise EXEC. Port changes after capture have no effect.
- EXEC (one cycle): compute the result and flags into the output registers, then DONE.
- Opcodes:
  - 100000 ADD: a+b mod 2^NB_DATA.
  - 100010 SUB: a-b.
  - 100100 AND.
  - 100101 OR.
  - 100110 XOR.
  - 100111 NOR.
  - 000000 SLL.
  - 000010 SRL: zero fill.
  - 000011 SRA: sign fill.
- Any other opcode: out=0, flag_err=1, flag_zero=1, carry/ovf=0.
- Flags:
  - Carry = bit NB_DATA of the unsigned add. For SUB, carry = 1 iff a < b unsigned (borrow).
  - Ovf for ADD = operands share a sign and the result sign differs. For SUB = operand signs differ and the result sign differs from a.
  - Carry/ovf are 0 for logic and shift ops. Zero is valid for every op.
- SHIFT: one-bit shift per cycle with a down-counter loaded from shamt.
  - shamt = 0 takes one cycle and passes a through unchanged.
  - Otherwise SHIFT lasts shamt cycles.
  - The result is written on the last SHIFT edge, then DONE.
  - Shift amount uses only dato_b[NB_SHAMT-1:0]; upper bits are ignored.
- Latency (accept edge = k):
  - Non-shift ops: out_valid high after edge k+1.
  - Shifts: out_valid high after edge k+max(1,shamt).
- DONE: out_valid=1; out and flags held stable until out_ready=1 at an edge, then IDLE. in_ready=0 in EXEC/SHIFT/DONE, so in_valid is ignored there. Consecutive operations are therefore at least one IDLE cycle apart.
- out/flags retain their last value after the handshake; consumers qualify them with out_valid only.
- Holding out_ready=1 permanently: DONE lasts exactly one cycle.

Test Plan:
- ADD a=8 b=2 -> out=10, zero/carry/ovf/err=0, out_valid 1 cycle after accept. SUB a=8 b=2 -> out=6. SUB a=2 b=8 -> out=250, carry=1, ovf=0.
- ADD a=127 b=1 -> out=128, ovf=1, carry=0. ADD a=255 b=1 -> out=0, carry=1, zero=1, ovf=0.
- a=3 b=1: OR -> 3, XOR -> 2, NOR -> 252, AND -> 1. Opcode 111111 -> out=0, err=1.
- SRA a=131 b=1 -> 193 after 1 cycle. SRL a=131 b=3 -> 16 after 3 cycles. SLL a=3 b=0 -> 3 after 1 cycle. SRL a=131 b=0x0B -> shamt 3, out=16.
- Backpressure: out_ready=0 for 5 cycles after a result; out/flags stable, out_valid=1, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset: assert rst_n=0 mid-SHIFT (SRL shamt 7, cycle 3) without a clock edge -> out_valid, out, flags go to 0 immediately. After release, an ADD 1+1 returns 2.
